// File: rtl/controle_jogo_sequencia.sv
// Moore control unit for the sequence-memory game: plays the stored sequence
// back up to the current limit, collects the player's answers and ends the game.
module controle_jogo_sequencia #(
  parameter int T_EXIBE   = 1000,
  parameter int T_APAGA   = 500,
  parameter int T_TIMEOUT = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fim_sequencia,
  input  logic       ultima_sequencia,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       exibe,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  localparam int T_MAX_AE = (T_EXIBE > T_APAGA) ? T_EXIBE : T_APAGA;
  localparam int T_MAX    = (T_MAX_AE > T_TIMEOUT) ? T_MAX_AE : T_TIMEOUT;
  localparam int TW       = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [TW-1:0] LIM_EXIBE   = TW'(T_EXIBE - 1);
  localparam logic [TW-1:0] LIM_APAGA   = TW'(T_APAGA - 1);
  localparam logic [TW-1:0] LIM_TIMEOUT = TW'(T_TIMEOUT - 1);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    EXIBE       = 4'h2,
    APAGA       = 4'h3,
    PROX_EXIBE  = 4'h4,
    INICIA_JOG  = 4'h5,
    ESPERA      = 4'h6,
    REGISTRA    = 4'h7,
    COMPARA     = 4'h8,
    PROX_JOG    = 4'h9,
    PROX_RODADA = 4'hA,
    FIM_ACERTO  = 4'hC,
    FIM_ERRO    = 4'hD,
    FIM_TIMEOUT = 4'hE
  } estado_t;

  estado_t         r_estado;
  estado_t         w_proximo;
  logic [TW-1:0]   r_timer;
  logic            w_cronometrado;
  logic            w_fim_exibe;
  logic            w_fim_apaga;
  logic            w_fim_espera;

  // NOTE: state and counters are flops, so they take non-blocking assignments;
  // blocking ones here would let readers in other processes race the update.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= INICIAL;
    end else begin
      r_estado <= w_proximo;
    end
  end

  // The timer only runs in the three timed states and restarts on every state
  // change, so each interval (including a fresh ESPERA after PROX_JOG) starts at 0.
  assign w_cronometrado = (r_estado == EXIBE) || (r_estado == APAGA) ||
                          (r_estado == ESPERA);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_timer <= '0;
    end else if (!w_cronometrado || (w_proximo != r_estado)) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  assign w_fim_exibe  = (r_timer == LIM_EXIBE);
  assign w_fim_apaga  = (r_timer == LIM_APAGA);
  assign w_fim_espera = (r_timer == LIM_TIMEOUT);

  // NOTE: the next-state default is assigned before the case so every path
  // drives w_proximo and no latch is inferred.
  always_comb begin
    w_proximo = r_estado;
    unique case (r_estado)
      INICIAL:     if (iniciar) w_proximo = PREPARA;
      PREPARA:     w_proximo = EXIBE;
      EXIBE:       if (w_fim_exibe) w_proximo = APAGA;
      APAGA: begin
        if (w_fim_apaga) w_proximo = fim_sequencia ? INICIA_JOG : PROX_EXIBE;
      end
      PROX_EXIBE:  w_proximo = EXIBE;
      INICIA_JOG:  w_proximo = ESPERA;
      ESPERA: begin
        // A key press on the expiry cycle still counts as a play.
        if (jogada)            w_proximo = REGISTRA;
        else if (w_fim_espera) w_proximo = FIM_TIMEOUT;
      end
      REGISTRA:    w_proximo = COMPARA;
      COMPARA: begin
        if (!igual)                                  w_proximo = FIM_ERRO;
        else if (fim_sequencia && ultima_sequencia)  w_proximo = FIM_ACERTO;
        else if (fim_sequencia)                      w_proximo = PROX_RODADA;
        else                                         w_proximo = PROX_JOG;
      end
      PROX_JOG:    w_proximo = ESPERA;
      PROX_RODADA: w_proximo = EXIBE;
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
        if (iniciar) w_proximo = PREPARA;
      end
      default:     w_proximo = INICIAL;
    endcase
  end

  // Outputs depend on the state register only.
  always_comb begin
    zeraE     = 1'b0;
    contaE    = 1'b0;
    zeraL     = 1'b0;
    contaL    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    exibe     = 1'b0;
    pronto    = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    timeout   = 1'b0;
    unique case (r_estado)
      PREPARA: begin
        zeraE = 1'b1;
        zeraL = 1'b1;
        zeraR = 1'b1;
      end
      EXIBE:       exibe = 1'b1;
      PROX_EXIBE:  contaE = 1'b1;
      INICIA_JOG: begin
        zeraE = 1'b1;
        zeraR = 1'b1;
      end
      REGISTRA:    registraR = 1'b1;
      PROX_JOG:    contaE = 1'b1;
      PROX_RODADA: begin
        contaL = 1'b1;
        zeraE  = 1'b1;
      end
      FIM_ACERTO: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      FIM_ERRO: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      FIM_TIMEOUT: begin
        pronto  = 1'b1;
        errou   = 1'b1;
        timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = r_estado;

endmodule
